// File: rtl/uart_pixel_cmd_parser.sv
// uart_pixel_cmd_parser: decodes 7-byte UART packets into RGB565 pixel writes plus an ACK/NAK response byte
module uart_pixel_cmd_parser #(
  parameter int          TimeoutCycles = 27000,
  parameter logic [7:0]  SyncByte      = 8'hA5,
  parameter logic [7:0]  AckByte       = 8'h06,
  parameter logic [7:0]  NakByte       = 8'h15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [16:0] o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [7:0]  o_resp_byte,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic        o_overrun
);
  localparam int CW = $clog2(TimeoutCycles + 1);
  typedef enum logic [3:0] {IDLE, CMD, ADDR_H, ADDR_L, DATA_H, DATA_L, CSUM, WRITE, RESP} state_t;
  state_t state, next_state;
  logic [7:0]    cmd, csum, resp_byte;
  logic [15:0]   addr, data;
  logic [CW-1:0] cnt;
  logic          err_timeout, collecting, expire, csum_ok;
  assign collecting = state != IDLE && state != WRITE && state != RESP;
  assign expire     = collecting && !i_rx_valid && cnt == CW'(TimeoutCycles - 1);
  assign csum_ok    = i_rx_byte == csum;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  // next state: one byte per strobe, handshakes leave WRITE/RESP, timeout abandons a partial packet
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_rx_valid && i_rx_byte == SyncByte) next_state = CMD;
      CMD:     if (i_rx_valid) next_state = ADDR_H;
      ADDR_H:  if (i_rx_valid) next_state = ADDR_L;
      ADDR_L:  if (i_rx_valid) next_state = DATA_H;
      DATA_H:  if (i_rx_valid) next_state = DATA_L;
      DATA_L:  if (i_rx_valid) next_state = CSUM;
      CSUM:    if (i_rx_valid) next_state = (csum_ok && cmd == 8'h01) ? WRITE : RESP;
      WRITE:   if (i_wr_ready) next_state = RESP;
      RESP:    if (i_resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (expire) next_state = IDLE;
  end
  // packet fields, running checksum, response byte and inter-byte timer
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cmd         <= '0;
      csum        <= '0;
      addr        <= '0;
      data        <= '0;
      resp_byte   <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= expire;
      cnt         <= (!collecting || i_rx_valid || expire) ? '0 : cnt + 1'b1;
      if (i_rx_valid)
        case (state)
          IDLE:    if (i_rx_byte == SyncByte) csum <= '0;
          CMD:     begin cmd <= i_rx_byte;         csum <= csum ^ i_rx_byte; end
          ADDR_H:  begin addr[15:8] <= i_rx_byte;  csum <= csum ^ i_rx_byte; end
          ADDR_L:  begin addr[7:0] <= i_rx_byte;   csum <= csum ^ i_rx_byte; end
          DATA_H:  begin data[15:8] <= i_rx_byte;  csum <= csum ^ i_rx_byte; end
          DATA_L:  begin data[7:0] <= i_rx_byte;   csum <= csum ^ i_rx_byte; end
          CSUM:    resp_byte <= (csum_ok && cmd == 8'h00) ? AckByte : NakByte;
          default: ;
        endcase
      if (state == WRITE && i_wr_ready) resp_byte <= AckByte;
    end
  // outputs decoded from the registered state and fields
  always_comb begin
    o_wr_valid    = state == WRITE;
    o_resp_valid  = state == RESP;
    o_busy        = state != IDLE;
    o_overrun     = i_rx_valid && (state == WRITE || state == RESP);
    o_wr_addr     = {1'b0, addr};
    o_wr_data     = data;
    o_resp_byte   = resp_byte;
    o_err_timeout = err_timeout;
  end
endmodule
